router_pkt_fifo: RTL and testbench

ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

---
 rtl/router_pkg.sv | 19 +
 rtl/router_pkt_fifo_if.sv | 36 +++
 rtl/router_pkt_tracker.sv | 51 +++++
 rtl/router_pkt_fifo.sv | 92 +++++++++
 tb/tb_router_pkt_fifo.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared constants and header decoding for the router packet FIFO.
// A header byte carries the payload length above a 2-bit destination address.
package router_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   // Header field bounds: address in [ADDR_W-1:0], length in [WIDTH-1:LEN_LSB].
   localparam int ADDR_W  = 2;
   localparam int LEN_LSB = ADDR_W;

   // Bytes that follow a header: payload length plus the trailing parity byte.
   function automatic logic [31:0] hdr_span(input logic [31:0] hdr_byte, input int width);
      logic [31:0] len_mask;
      len_mask = (32'd1 << (width - LEN_LSB)) - 32'd1;
      return ((hdr_byte >> LEN_LSB) & len_mask) + 32'd1;
   endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read handshake and status bundle of the router packet FIFO.
// The master side feeds bytes and pulls reads; the slave side is the FIFO.
interface router_pkt_fifo_if #(
   parameter int WIDTH = router_pkg::DEF_WIDTH,
   parameter int DEPTH = router_pkg::DEF_DEPTH
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             write_enb;
   logic             lfd_state;
   logic [WIDTH-1:0] data_in;
   logic             read_enb;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             sop;
   logic             eop;
   logic             empty;
   logic             full;
   logic             almost_full;
   logic [LW-1:0]    level;
   logic             overflow;
   logic             frame_err;

   modport master (
      output write_enb, lfd_state, data_in, read_enb,
      input  data_out, data_valid, sop, eop, empty, full, almost_full, level,
             overflow, frame_err
   );

   modport slave (
      input  write_enb, lfd_state, data_in, read_enb,
      output data_out, data_valid, sop, eop, empty, full, almost_full, level,
             overflow, frame_err
   );

endinterface

// File: rtl/router_pkt_tracker.sv
// Read-side packet framing: follows header/payload/parity order of bytes leaving
// the FIFO and flags truncated packets and orphan bytes.
module router_pkt_tracker
   import router_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             rd_valid,
   input  logic             rd_hdr,
   input  logic [WIDTH-1:0] rd_byte,
   output logic             sop,
   output logic             eop,
   output logic             frame_err
);
   localparam int RW = WIDTH - 1;

   logic [RW-1:0] remaining_reg;
   logic          frame_err_reg;
   logic          truncated;
   logic          orphan;

   assign truncated = rd_valid && rd_hdr && (remaining_reg != '0);
   assign orphan    = rd_valid && !rd_hdr && (remaining_reg == '0);

   // Outputs qualify the registered read data, so they line up with data_out.
   assign sop       = rd_valid && rd_hdr;
   assign eop       = rd_valid && !rd_hdr && (remaining_reg == RW'(1));
   assign frame_err = frame_err_reg || truncated || orphan;

   always_ff @(posedge clock) begin
      if (!resetn || soft_reset) begin
         remaining_reg <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         if (truncated || orphan) begin
            frame_err_reg <= 1'b1;
         end
         if (rd_valid) begin
            if (rd_hdr) begin
               remaining_reg <= RW'(hdr_span(32'(rd_byte), WIDTH));
            end else if (remaining_reg != '0) begin
               remaining_reg <= remaining_reg - RW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet FIFO for the router: stores {header flag, byte}, exposes occupancy
// status and sticky overflow, and hands read-side framing to the tracker.
module router_pkt_fifo
   import router_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = 2
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             soft_reset,
   router_pkt_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [WIDTH:0]  mem [DEPTH];
   logic [PW-1:0]   wr_ptr_reg;
   logic [PW-1:0]   rd_ptr_reg;
   logic [PW-1:0]   level_w;
   logic [PW-1:0]   free_w;
   logic [WIDTH:0]  rd_entry_reg;
   logic            data_valid_reg;
   logic            overflow_reg;
   logic            flush;
   logic            empty_w;
   logic            full_w;
   logic            wr_fire;
   logic            rd_fire;

   assign flush   = !resetn || soft_reset;
   assign empty_w = (wr_ptr_reg == rd_ptr_reg);
   assign full_w  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign wr_fire = bus.write_enb && !full_w;
   assign rd_fire = bus.read_enb && !empty_w;
   assign level_w = wr_ptr_reg - rd_ptr_reg;
   assign free_w  = PW'(DEPTH) - level_w;

   // Storage array is never reset; stale flags sit behind equal pointers.
   always_ff @(posedge clock) begin
      if (wr_fire && !flush) begin
         mem[wr_ptr_reg[AW-1:0]] <= {bus.lfd_state, bus.data_in};
      end
   end

   always_ff @(posedge clock) begin
      if (flush) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         rd_entry_reg   <= '0;
         data_valid_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         if (wr_fire) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (rd_fire) begin
            rd_ptr_reg   <= rd_ptr_reg + PW'(1);
            rd_entry_reg <= mem[rd_ptr_reg[AW-1:0]];
         end
         data_valid_reg <= rd_fire;
         if (bus.write_enb && full_w) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign bus.data_out    = rd_entry_reg[WIDTH-1:0];
   assign bus.data_valid  = data_valid_reg;
   assign bus.empty       = empty_w;
   assign bus.full        = full_w;
   assign bus.level       = level_w;
   assign bus.almost_full = (free_w <= PW'(AF_THRESH));
   assign bus.overflow    = overflow_reg;

   router_pkt_tracker #(
      .WIDTH(WIDTH)
   ) u_tracker (
      .clock     (clock),
      .resetn    (resetn),
      .soft_reset(soft_reset),
      .rd_valid  (data_valid_reg),
      .rd_hdr    (rd_entry_reg[WIDTH]),
      .rd_byte   (rd_entry_reg[WIDTH-1:0]),
      .sop       (bus.sop),
      .eop       (bus.eop),
      .frame_err (bus.frame_err)
   );

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: a queue-based packet model checked every
// cycle, plus literal expectations on the key scenarios.
module tb_router_pkt_fifo;
   localparam int DEPTH = 16;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic soft_reset = 1'b0;

   router_pkt_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus_if ();

   router_pkt_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AF_THRESH(2)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .soft_reset(soft_reset),
      .bus       (bus_if)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   // Model state
   logic [8:0] m_q[$];
   logic       m_valid = 1'b0;
   logic [7:0] m_data  = 8'h00;
   logic       m_sop   = 1'b0;
   logic       m_eop   = 1'b0;
   logic       m_ferr  = 1'b0;
   logic       m_ovf   = 1'b0;
   int         m_left  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock) begin
      bit was_full;
      bit was_empty;
      logic [8:0] e;
      if (!resetn || soft_reset) begin
         m_q.delete();
         m_valid = 0; m_data = 0; m_sop = 0; m_eop = 0;
         m_ferr = 0; m_ovf = 0; m_left = 0;
      end else begin
         was_full  = (m_q.size() == DEPTH);
         was_empty = (m_q.size() == 0);
         m_valid = 0; m_sop = 0; m_eop = 0;
         if (bus_if.read_enb && !was_empty) begin
            e = m_q.pop_front();
            m_valid = 1;
            m_data  = e[7:0];
            if (e[8]) begin
               m_sop = 1;
               if (m_left > 0) m_ferr = 1;
               m_left = int'(e[7:2]) + 1;
            end else if (m_left > 0) begin
               m_left--;
               if (m_left == 0) m_eop = 1;
            end else begin
               m_ferr = 1;
            end
         end
         if (bus_if.write_enb) begin
            if (was_full) m_ovf = 1;
            else m_q.push_back({bus_if.lfd_state, bus_if.data_in});
         end
      end
   end

   always @(negedge clock) begin
      if (chk_on) begin
         chk("empty",       bus_if.empty,       32'(m_q.size() == 0));
         chk("full",        bus_if.full,        32'(m_q.size() == DEPTH));
         chk("level",       bus_if.level,       32'(m_q.size()));
         chk("almost_full", bus_if.almost_full, 32'((DEPTH - m_q.size()) <= 2));
         chk("data_valid",  bus_if.data_valid,  32'(m_valid));
         chk("data_out",    bus_if.data_out,    32'(m_data));
         chk("sop",         bus_if.sop,         32'(m_sop));
         chk("eop",         bus_if.eop,         32'(m_eop));
         chk("frame_err",   bus_if.frame_err,   32'(m_ferr));
         chk("overflow",    bus_if.overflow,    32'(m_ovf));
      end
   end

   task automatic tick(input logic we, input logic lfd, input logic [7:0] din,
                       input logic re, input logic sr);
      bus_if.write_enb = we;
      bus_if.lfd_state = lfd;
      bus_if.data_in   = din;
      bus_if.read_enb  = re;
      soft_reset       = sr;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wr(input logic hdr, input logic [7:0] b);
      tick(1'b1, hdr, b, 1'b0, 1'b0);
      $display("[TB] write hdr=%0b byte=%02h level=%0d", hdr, b, bus_if.level);
   endtask

   task automatic rd();
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      $display("[TB] read valid=%0b data=%02h sop=%0b eop=%0b ferr=%0b",
               bus_if.data_valid, bus_if.data_out, bus_if.sop, bus_if.eop, bus_if.frame_err);
   endtask

   task automatic flush();
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      $display("[TB] soft_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] last;
      bus_if.write_enb = 0; bus_if.lfd_state = 0; bus_if.data_in = 0; bus_if.read_enb = 0;
      resetn = 0;
      @(posedge clock); @(posedge clock); @(negedge clock);
      resetn = 1;
      chk_on = 1;
      chk("rst_empty", bus_if.empty, 1);
      chk("rst_full", bus_if.full, 0);
      chk("rst_level", bus_if.level, 0);
      chk("rst_valid", bus_if.data_valid, 0);
      chk("rst_ovf", bus_if.overflow, 0);
      chk("rst_ferr", bus_if.frame_err, 0);

      // Length-3 packet: header, 3 payload, parity.
      wr(1, 8'h0C); wr(0, 8'h11); wr(0, 8'h22); wr(0, 8'h33); wr(0, 8'h44);
      for (int i = 0; i < 5; i++) begin
         rd();
         chk("pkt3_valid", bus_if.data_valid, 1);
         chk("pkt3_sop", bus_if.sop, 32'(i == 0));
         chk("pkt3_eop", bus_if.eop, 32'(i == 4));
      end
      chk("pkt3_parity", bus_if.data_out, 8'h44);
      chk("pkt3_ferr", bus_if.frame_err, 0);
      tick(0, 0, 0, 0, 0);
      chk("pkt3_idle_valid", bus_if.data_valid, 0);
      chk("pkt3_hold_data", bus_if.data_out, 8'h44);

      // Length-0 packet, then a header cut short by another header.
      wr(1, 8'h00); wr(0, 8'hA5);
      rd(); chk("len0_sop", bus_if.sop, 1);
      rd(); chk("len0_eop", bus_if.eop, 1);
      chk("len0_ferr", bus_if.frame_err, 0);
      wr(1, 8'h04); wr(1, 8'h00);
      rd(); chk("hh_ferr0", bus_if.frame_err, 0);
      rd(); chk("hh_ferr1", bus_if.frame_err, 1);
      tick(0, 0, 0, 0, 0);
      chk("hh_sticky", bus_if.frame_err, 1);

      // Fill to full, then one more write.
      flush();
      for (int i = 0; i < 16; i++) begin
         wr(0, 8'(i * 3 + 1));
         if (i == 12) chk("af_13", bus_if.almost_full, 0);
         if (i == 13) chk("af_14", bus_if.almost_full, 1);
      end
      wr(0, 8'hEE);
      chk("ovf_full", bus_if.full, 1);
      chk("ovf_level", bus_if.level, 16);
      chk("ovf_flag", bus_if.overflow, 1);
      for (int i = 0; i < 16; i++) begin
         rd();
         last = bus_if.data_out;
         chk("drain_data", last, 32'(8'(i * 3 + 1)));
      end
      chk("drain_empty", bus_if.empty, 1);

      // Full FIFO with read and write in the same cycle.
      flush();
      for (int i = 0; i < 16; i++) wr(0, 8'(8'h80 + i));
      tick(1, 0, 8'h5A, 1, 0);
      $display("[TB] rw_full valid=%0b data=%02h level=%0d", bus_if.data_valid, bus_if.data_out, bus_if.level);
      chk("rwf_valid", bus_if.data_valid, 1);
      chk("rwf_data", bus_if.data_out, 8'h80);
      chk("rwf_level", bus_if.level, 15);
      chk("rwf_ovf", bus_if.overflow, 1);

      // Repeated fill/drain across pointer wraps.
      flush();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) wr(0, 8'(r * 16 + i));
         for (int i = 0; i < 8; i++) begin
            rd();
            chk("wrap_data", bus_if.data_out, 32'(8'(r * 16 + i)));
         end
      end
      chk("wrap_empty", bus_if.empty, 1);

      // Flush mid-packet while reading, then an orphan payload byte.
      flush();
      wr(1, 8'h0C); wr(0, 8'h01); wr(0, 8'h02); wr(0, 8'h03);
      rd(); rd();
      tick(0, 0, 0, 1, 1);
      $display("[TB] flush_mid valid=%0b empty=%0b level=%0d", bus_if.data_valid, bus_if.empty, bus_if.level);
      chk("fm_valid", bus_if.data_valid, 0);
      chk("fm_empty", bus_if.empty, 1);
      chk("fm_level", bus_if.level, 0);
      wr(0, 8'h55);
      rd();
      chk("orphan_data", bus_if.data_out, 8'h55);
      chk("orphan_ferr", bus_if.frame_err, 1);
      chk("orphan_sop", bus_if.sop, 0);
      chk("orphan_eop", bus_if.eop, 0);
      tick(0, 0, 0, 0, 0);

      chk_on = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
